// File: rtl/spi_ram_slave.sv
// rtl/spi_ram_slave.sv - SPI mode-0 slave decoding host frames into 16x8 RAM accesses
module spi_ram_slave #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout,
  output logic          ram_enable,
  output logic          ram_rw,
  output logic [AW-1:0] ram_adrs,
  output logic          frame_done,
  output logic          frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, RD_ISSUE, RD_LOAD, DATA, WR_COMMIT} state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_d1_q;
  logic cs_s1_q, cs_s2_q, cs_d1_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d1_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d1_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d1_q <= sclk_s2_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_d1_q   <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic rise, fall, cs_fall, cs_rise;
  assign rise    =  sclk_s2_q & ~sclk_d1_q;
  assign fall    = ~sclk_s2_q &  sclk_d1_q;
  assign cs_fall = ~cs_s2_q   &  cs_d1_q;
  assign cs_rise =  cs_s2_q   & ~cs_d1_q;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d, miso_q, miso_d;
  logic          done_q, done_d, err_q, err_d;

  logic [7:0]    cnt_inc;
  logic          byte_end;
  logic [DW-1:0] shift_in;

  // Saturated counter never reports another byte boundary.
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign byte_end = (cnt_q != 8'hFF) && (cnt_inc[2:0] == 3'd0);
  assign shift_in = {rx_q[DW-2:0], mosi_s2_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (cs_fall) begin
      state_d = CMD;
      cnt_d   = 8'd0;
      rx_d    = '0;
      tx_d    = '0;
      miso_d  = 1'b0;
    end else if (cs_rise && state_q != IDLE) begin
      // Deselect beats any simultaneous sclk edge; a partial byte is dropped.
      state_d = IDLE;
      miso_d  = 1'b0;
      if (cnt_q >= 8'd16 && cnt_q[2:0] == 3'd0) done_d = 1'b1;
      else                                      err_d  = 1'b1;
    end else begin
      if (rise && state_q != IDLE) cnt_d = cnt_inc;
      case (state_q)
        CMD: begin
          if (rise) begin
            rx_d = shift_in;
            if (byte_end) begin
              addr_d  = shift_in[AW-1:0];
              rd_d    = shift_in[DW-1];
              state_d = shift_in[DW-1] ? RD_ISSUE : DATA;
            end
          end
        end
        RD_ISSUE: state_d = RD_LOAD;
        RD_LOAD: begin
          tx_d    = ram_dataout;
          state_d = DATA;
        end
        DATA: begin
          if (rd_q) begin
            if (fall) begin
              miso_d = tx_q[DW-1];
              tx_d   = {tx_q[DW-2:0], 1'b0};
            end
            if (rise && byte_end) begin
              addr_d  = addr_q + 1'b1;
              state_d = RD_ISSUE;
            end
          end else if (rise) begin
            rx_d = shift_in;
            if (byte_end) state_d = WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          addr_d  = addr_q + 1'b1;
          state_d = DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // An in-flight write commit is allowed to finish even when deselected.
  assign ram_enable = (state_q == RD_ISSUE && !cs_rise) || (state_q == WR_COMMIT);
  assign ram_rw     = (state_q != WR_COMMIT);
  assign ram_adrs   = addr_q;
  assign ram_datain = rx_q;
  assign miso       = miso_q;
  assign miso_oe    = ~cs_s2_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
